// File: rtl/exmem_pipe.sv
// EX/MEM pipeline stage with valid/ready handshake, flush and branch resolve.
// Define EXMEM_SKID_EN for a 2-entry skid buffer with registered in_ready.
module exmem_pipe #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               MemtoReg,
  input  logic               RegWrite,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               Branch,
  input  logic               BranchNE,
  input  logic               zero,
  input  logic [XLEN-1:0]    pc4branched,
  input  logic [XLEN-1:0]    ALUres,
  input  logic [XLEN-1:0]    rd2,
  input  logic [RADDR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               MemtoRego,
  output logic               RegWriteo,
  output logic               MemReado,
  output logic               MemWriteo,
  output logic               Brancho,
  output logic               BranchNEo,
  output logic               zeroo,
  output logic [XLEN-1:0]    pc4branchedo,
  output logic [XLEN-1:0]    ALUreso,
  output logic [XLEN-1:0]    rd2o,
  output logic [RADDR_W-1:0] instro,
  output logic               pcsrc
);

  typedef struct packed {
    logic [6:0]         ctl;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    rd2;
    logic [RADDR_W-1:0] rd;
  } pl_t;

  pl_t  in_pl;
  pl_t  main_pl;
  pl_t  main_src;
  logic main_valid;
  logic main_free;
  logic accept;
  logic load_main;

  assign in_pl = {MemtoReg, RegWrite, MemRead, MemWrite,
                  Branch, BranchNE, zero,
                  pc4branched, ALUres, rd2, instr};

  assign main_free = ~main_valid | out_ready;
  assign accept    = in_valid & in_ready;

`ifdef EXMEM_SKID_EN
  pl_t  skid_pl;
  logic skid_valid;

  // in_ready comes straight from a flop: no path from out_ready
  assign in_ready  = ~skid_valid;
  assign load_main = main_free & (skid_valid | accept);
  assign main_src  = skid_valid ? skid_pl : in_pl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_pl    <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (main_free) begin
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_pl    <= in_pl;
    end
  end
`else
  assign in_ready  = main_free;
  assign load_main = main_free & accept;
  assign main_src  = in_pl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_pl    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (main_free) begin
      main_valid <= load_main;
      if (load_main) main_pl <= main_src;
    end
  end

  // bubbles carry all-zero control so they never write state
  assign {MemtoRego, RegWriteo, MemReado, MemWriteo,
          Brancho, BranchNEo, zeroo} = main_pl.ctl & {7{main_valid}};

  assign out_valid    = main_valid;
  assign pc4branchedo = main_pl.pc;
  assign ALUreso      = main_pl.alu;
  assign rd2o         = main_pl.rd2;
  assign instro       = main_pl.rd;

  assign pcsrc = main_valid &
                 ((Brancho & zeroo) | (BranchNEo & ~zeroo));

endmodule

// File: tb/tb_exmem_pipe.sv
// Bench for exmem_pipe: queue-based reference model plus directed checks.
// Follows EXMEM_SKID_EN to pick capacity and in_ready behaviour.
module tb_exmem_pipe;

`ifdef EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd;
  } it_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic        MemtoReg, RegWrite, MemRead, MemWrite;
  logic        Branch, BranchNE, zero;
  logic [31:0] pc4branched, ALUres, rd2;
  logic [4:0]  instr;
  logic        out_valid, out_ready;
  logic        MemtoRego, RegWriteo, MemReado, MemWriteo;
  logic        Brancho, BranchNEo, zeroo;
  logic [31:0] pc4branchedo, ALUreso, rd2o;
  logic [4:0]  instro;
  logic        pcsrc;
  logic [6:0]  octl;

  int checks = 0;
  int errors = 0;

  it_t         mq[$];
  it_t         pend[$];
  logic [31:0] got[$];
  int          nacc;
  logic        rdy_low;

  exmem_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .BranchNE(BranchNE), .zero(zero),
    .pc4branched(pc4branched), .ALUres(ALUres),
    .rd2(rd2), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .MemtoRego(MemtoRego), .RegWriteo(RegWriteo),
    .MemReado(MemReado), .MemWriteo(MemWriteo),
    .Brancho(Brancho), .BranchNEo(BranchNEo),
    .zeroo(zeroo),
    .pc4branchedo(pc4branchedo), .ALUreso(ALUreso),
    .rd2o(rd2o), .instro(instro),
    .pcsrc(pcsrc)
  );

  always #5 clk = ~clk;

  assign octl = {MemtoRego, RegWriteo, MemReado, MemWriteo,
                 Brancho, BranchNEo, zeroo};

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic it_t mk(logic [31:0] alu,
                             logic [6:0] ctl);
    it_t x;
    x.ctl = ctl;
    x.pc  = $urandom;
    x.alu = alu;
    x.rd2 = $urandom;
    x.rd  = 5'($urandom);
    return x;
  endfunction

  task automatic put(it_t x);
    {MemtoReg, RegWrite, MemRead, MemWrite,
     Branch, BranchNE, zero} = x.ctl;
    pc4branched = x.pc;
    ALUres      = x.alu;
    rd2         = x.rd2;
    instr       = x.rd;
  endtask

  function automatic logic model_rdy();
    if (CAP == 2) return mq.size() < 2;
    return mq.size() == 0 || out_ready;
  endfunction

  // upstream holds its head item until accepted
  task automatic cyc();
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      put(pend[0]);
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    if (!in_ready) rdy_low = 1'b1;
    if (in_valid && in_ready) begin
      pend.delete(0);
      nacc++;
    end
    if (out_valid && out_ready) got.push_back(ALUreso);
    @(posedge clk);
    #1;
  endtask

  // reference model: FIFO of in-flight instructions
  initial begin : cmp
    it_t  f, inp;
    logic ev, acc, fl, ordy, e_pc;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ev = mq.size() > 0;
        f  = ev ? mq[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(model_rdy()));
        chk("ctl", 32'(octl), ev ? 32'(f.ctl) : 32'd0);
        e_pc = ev & ((f.ctl[2] & f.ctl[0]) |
                     (f.ctl[1] & ~f.ctl[0]));
        chk("pcsrc", 32'(pcsrc), 32'(e_pc));
        if (ev) begin
          chk("ALUreso", ALUreso, f.alu);
          chk("pc4o", pc4branchedo, f.pc);
          chk("rd2o", rd2o, f.rd2);
          chk("instro", 32'(instro), 32'(f.rd));
        end
      end
      acc  = in_valid & model_rdy();
      fl   = flush;
      ordy = out_ready;
      inp.ctl = {MemtoReg, RegWrite, MemRead, MemWrite,
                 Branch, BranchNE, zero};
      inp.pc  = pc4branched;
      inp.alu = ALUres;
      inp.rd2 = rd2;
      inp.rd  = instr;
      @(posedge clk);
      if (!rst_n || fl) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && ordy) mq.delete(0);
        if (acc) mq.push_back(inp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    put('0);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst ALUreso", ALUreso, 0);
    chk("rst pc4o", pc4branchedo, 0);
    chk("rst ctl", 32'(octl), 0);
    chk("rst pcsrc", 32'(pcsrc), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // streaming at full rate
    out_ready = 1'b1;
    got.delete();
    rdy_low = 1'b0;
    pend.push_back(mk(32'h10, 7'b0100000));
    pend.push_back(mk(32'h20, 7'b0100000));
    pend.push_back(mk(32'h30, 7'b0100000));
    repeat (4) cyc();
    chk("stream count", got.size(), 3);
    if (got.size() == 3) begin
      chk("stream 0", got[0], 32'h10);
      chk("stream 1", got[1], 32'h20);
      chk("stream 2", got[2], 32'h30);
    end
    chk("stream in_ready", 32'(rdy_low), 0);
    repeat (2) cyc();

    // stall: capacity then back-pressure
    out_ready = 1'b0;
    nacc = 0;
    pend.push_back(mk(32'h11, 7'b0001000));
    pend.push_back(mk(32'h22, 7'b0001000));
    pend.push_back(mk(32'h33, 7'b0001000));
    repeat (3) cyc();
    chk("stall accepted", nacc, CAP);
    chk("stall in_ready", 32'(in_ready), 0);
    chk("stall hold", ALUreso, 32'h11);
    out_ready = 1'b1;
    got.delete();
    repeat (5) cyc();
    chk("drain count", got.size(), 3);
    if (got.size() == 3) begin
      chk("drain 0", got[0], 32'h11);
      chk("drain 1", got[1], 32'h22);
      chk("drain 2", got[2], 32'h33);
    end

    // branch resolution
    in_valid = 1'b1;
    put(mk(32'h40, 7'b0000101));
    @(posedge clk);
    #1;
    chk("pcsrc beq", 32'(pcsrc), 1);
    put(mk(32'h44, 7'b0000011));
    @(posedge clk);
    #1;
    chk("pcsrc bne", 32'(pcsrc), 0);
    in_valid = 1'b0;
    repeat (2) cyc();

    // flush with full buffer and a simultaneous offer
    out_ready = 1'b0;
    pend.push_back(mk(32'h51, 7'b0101000));
    pend.push_back(mk(32'h52, 7'b0101000));
    repeat (2) cyc();
    pend.delete();
    in_valid = 1'b1;
    put(mk(32'h99, 7'b0101000));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush RegWriteo", 32'(RegWriteo), 0);
    chk("flush MemWriteo", 32'(MemWriteo), 0);
    chk("flush in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    got.delete();
    repeat (3) cyc();
    chk("flush lost", got.size(), 0);

    // in_ready dependence on out_ready with one entry
    out_ready = 1'b0;
    in_valid = 1'b1;
    put(mk(32'h61, 7'b0100000));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("one entry in_ready", 32'(in_ready), CAP - 1);
    out_ready = 1'b1;
    #1;
    chk("ready comb in_ready", 32'(in_ready), 1);
    repeat (2) cyc();

    // asynchronous reset while stalled
    out_ready = 1'b0;
    pend.push_back(mk(32'h71, 7'b0100000));
    pend.push_back(mk(32'h72, 7'b0100000));
    repeat (2) cyc();
    pend.delete();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst ALUreso", ALUreso, 0);
    chk("arst ctl", 32'(octl), 0);
    chk("arst in_ready", 32'(in_ready), 1);
    chk("arst pcsrc", 32'(pcsrc), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      if (pend.size() < 2 && $urandom_range(0, 3) != 0)
        pend.push_back(mk($urandom, 7'($urandom)));
      cyc();
    end
    flush = 1'b0;
    pend.delete();
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
